// File: rtl/vram_client_port.sv
// vram_client_port: single-outstanding request port between a local user and a round-robin VRAM arbiter slot
// Ports: clk/rst (async active-low) | req_*: user request handshake | rsp_*: response handshake
//        grant: arbiter slot | vram_*: address/data/write-enable to arbiter, shared read bus back
module vram_client_port #(
  parameter int DATA_W   = 640,
  parameter int ADDR_W   = 9,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              grant,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_rdata
);
  typedef enum logic [1:0] {IDLE, ARMED, RDWAIT, RESP} state_t;
  localparam logic [1:0] LAT = 2'(READ_LAT);
  state_t r_state, w_next;
  logic r_we, r_rsp_we;
  logic [1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic w_go, w_last;
  // req_ready is gated by rst so it reads 0 throughout reset even though IDLE is the reset state
  assign req_ready  = rst & (r_state == IDLE);
  assign w_go       = (r_state == ARMED) & grant;
  assign w_last     = (r_state == RDWAIT) & (r_cnt == 2'd1);
  assign vram_we    = w_go & r_we;
  assign vram_addr  = r_addr;
  assign vram_wdata = r_wdata;
  assign rsp_valid  = r_state == RESP;
  assign rsp_we     = r_rsp_we;
  assign rsp_rdata  = r_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? ARMED : IDLE;
      ARMED:   w_next = grant ? (r_we ? RESP : RDWAIT) : ARMED;
      RDWAIT:  w_next = (r_cnt == 2'd1) ? RESP : RDWAIT;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  // The registered request only changes on a handshake, so the VRAM bus holds its last value outside ARMED
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rsp_we <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (req_valid & req_ready) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_go) r_cnt <= LAT;
      else if (r_state == RDWAIT) r_cnt <= r_cnt - 2'd1;
      if (w_go & r_we) r_rsp_we <= 1'b1;
      if (w_last) begin
        r_rsp_we <= 1'b0;
        r_rdata  <= vram_rdata;
      end
    end
endmodule

// File: tb/tb_vram_client_port.sv
// tb_vram_client_port: directed bench with a transaction-level timing model checked every cycle
module tb_vram_client_port;
  localparam int DW = 640;
  localparam int AW = 9;
  localparam int RL = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 0, req_we = 0, rsp_ready = 1, grant = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0, vram_rdata = '0;
  logic req_ready, rsp_valid, rsp_we, vram_we;
  logic [DW-1:0] rsp_rdata, vram_wdata;
  logic [AW-1:0] vram_addr;
  int n_chk = 0, n_fail = 0;
  logic q_we[$];
  logic [DW-1:0] pa, pb, pc, pd, pe;

  vram_client_port #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .grant(grant), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Model: one outstanding request described by when it was accepted, granted and answered
  int cyc = 0, m_gcyc = 0, m_due = 0;
  logic m_have = 0, m_iss = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_data = '0;
  always @(negedge clk) begin
    logic e_rr, e_vwe, e_rv;
    if (!rst) begin
      chk("rst_req_ready", DW'(req_ready), '0);
      chk("rst_rsp_valid", DW'(rsp_valid), '0);
      chk("rst_rsp_we", DW'(rsp_we), '0);
      chk("rst_vram_we", DW'(vram_we), '0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_vram_addr", DW'(vram_addr), '0);
      chk("rst_vram_wdata", vram_wdata, '0);
      m_have = 0; m_iss = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_data = '0;
    end else begin
      e_rr  = !m_have;
      e_vwe = m_have && !m_iss && m_we && grant;
      e_rv  = m_have && m_iss && cyc >= m_due;
      chk("m_req_ready", DW'(req_ready), DW'(e_rr));
      chk("m_vram_we", DW'(vram_we), DW'(e_vwe));
      chk("m_rsp_valid", DW'(rsp_valid), DW'(e_rv));
      chk("m_vram_addr", DW'(vram_addr), DW'(m_addr));
      chk("m_vram_wdata", vram_wdata, m_wdata);
      if (e_rv) begin
        chk("m_rsp_we", DW'(rsp_we), DW'(m_we));
        if (!m_we) chk("m_rsp_rdata", rsp_rdata, m_data);
        if (rsp_ready) begin
          q_we.push_back(m_we);
          m_have = 0;
        end
      end
      if (e_rr && req_valid) begin
        m_have = 1; m_iss = 0; m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
      end else if (m_have && !m_iss && grant) begin
        m_iss = 1; m_gcyc = cyc; m_due = cyc + (m_we ? 1 : RL + 1);
      end else if (m_have && m_iss && !m_we && cyc == m_gcyc + RL) begin
        m_data = vram_rdata;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
  endtask

  initial begin
    pa = {20{32'hA5A5_0001}};
    pb = {20{32'h3C3C_C3C3}};
    pc = {20{32'h1234_5678}};
    pd = {20{32'hDEAD_BEEF}};
    pe = {20{32'h0F0F_7070}};
    #1 rst = 0;
    #1;
    chk("reset_req_ready", DW'(req_ready), '0);
    chk("reset_rsp_valid", DW'(rsp_valid), '0);
    chk("reset_vram_addr", DW'(vram_addr), '0);
    step(); step();
    rst = 1;
    step();
    chk("after_reset_req_ready", DW'(req_ready), DW'(1'b1));
    // write, grant four cycles after accept
    put(1, 9'h05A, pa);
    step();
    req_valid = 0;
    #1 chk("wr_req_ready_busy", DW'(req_ready), '0);
    step(); step(); step();
    grant = 1;
    #1;
    chk("wr_vram_we", DW'(vram_we), DW'(1'b1));
    chk("wr_vram_addr", DW'(vram_addr), DW'(9'h05A));
    chk("wr_vram_wdata", vram_wdata, pa);
    step();
    grant = 0;
    #1;
    chk("wr_rsp_valid", DW'(rsp_valid), DW'(1'b1));
    chk("wr_rsp_we", DW'(rsp_we), DW'(1'b1));
    chk("wr_vram_we_after", DW'(vram_we), '0);
    step();
    // read, data on the cycle after grant
    put(0, 9'h1FF, '0);
    step();
    req_valid = 0; grant = 1;
    #1 chk("rd_vram_we", DW'(vram_we), '0);
    step();
    grant = 0; vram_rdata = pb;
    #1 chk("rd_not_yet_valid", DW'(rsp_valid), '0);
    step();
    vram_rdata = '0;
    #1;
    chk("rd_rsp_valid", DW'(rsp_valid), DW'(1'b1));
    chk("rd_rsp_rdata", rsp_rdata, pb);
    chk("rd_rsp_we", DW'(rsp_we), '0);
    step();
    // grant during handshake and during response are ignored
    rsp_ready = 0;
    put(1, 9'h033, ~pa);
    grant = 1;
    #1 chk("hs_grant_vram_we", DW'(vram_we), '0);
    step();
    req_valid = 0; grant = 0;
    repeat (7) step();
    grant = 1;
    #1;
    chk("late_grant_vram_we", DW'(vram_we), DW'(1'b1));
    chk("late_grant_addr", DW'(vram_addr), DW'(9'h033));
    step();
    #1;
    chk("resp_grant_vram_we", DW'(vram_we), '0);
    chk("resp_grant_valid", DW'(rsp_valid), DW'(1'b1));
    grant = 0; rsp_ready = 1;
    step();
    // response stall across grant pulses
    put(0, 9'h0AB, '0);
    step();
    req_valid = 0; grant = 1;
    step();
    grant = 0; vram_rdata = pc; rsp_ready = 0;
    step();
    vram_rdata = '0;
    for (int i = 0; i < 20; i++) begin
      put(1, 9'h077, pe);
      grant = (i == 3 || i == 9 || i == 15);
      #1;
      chk("stall_rsp_valid", DW'(rsp_valid), DW'(1'b1));
      chk("stall_rsp_rdata", rsp_rdata, pc);
      chk("stall_req_ready", DW'(req_ready), '0);
      chk("stall_vram_we", DW'(vram_we), '0);
      step();
    end
    req_valid = 0; grant = 0; rsp_ready = 1;
    step();
    // reset while armed with a write, one cycle before its grant
    put(1, 9'h111, pa);
    step();
    req_valid = 0;
    step();
    #2 rst = 0;
    #1;
    chk("midrst_req_ready", DW'(req_ready), '0);
    chk("midrst_rsp_valid", DW'(rsp_valid), '0);
    chk("midrst_rsp_we", DW'(rsp_we), '0);
    chk("midrst_vram_we", DW'(vram_we), '0);
    chk("midrst_rsp_rdata", rsp_rdata, '0);
    chk("midrst_vram_addr", DW'(vram_addr), '0);
    chk("midrst_vram_wdata", vram_wdata, '0);
    step();
    grant = 1;
    #1 chk("midrst_grant_vram_we", DW'(vram_we), '0);
    grant = 0; rst = 1;
    step();
    chk("post_rst_req_ready", DW'(req_ready), DW'(1'b1));
    chk("post_rst_rsp_valid", DW'(rsp_valid), '0);
    // back-to-back read then write to row 0
    q_we.delete();
    put(0, 9'h000, '0);
    step();
    req_valid = 0; grant = 1;
    step();
    grant = 0; vram_rdata = pd;
    step();
    vram_rdata = '0;
    put(1, 9'h000, pe);
    #1 chk("b2b_rd_rdata", rsp_rdata, pd);
    step();
    step();
    req_valid = 0; grant = 1;
    #1 chk("b2b_wr_vram_we", DW'(vram_we), DW'(1'b1));
    step();
    grant = 0;
    step();
    step();
    chk("b2b_count", DW'(q_we.size()), DW'(2));
    if (q_we.size() == 2) begin
      chk("b2b_first_we", DW'(q_we[0]), '0);
      chk("b2b_second_we", DW'(q_we[1]), DW'(1'b1));
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_client_port.md
VRAM_CLIENT_PORT -- requirements
Module: vram_client_port

Interface
REQ-001 Parameter DATA_W, default 640: VRAM row width in bits.
REQ-002 Parameter ADDR_W, default 9: VRAM row address width.
REQ-003 Parameter READ_LAT, default 1, legal range 1..3: cycles from grant-cycle edge to valid vram_rdata.
REQ-004 The block SHALL use one clock, clk; reset is rst, asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  local user offers a request.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  row address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  user accepts response.
REQ-014 rsp_we  output  1  response is a write acknowledge, not read data.
REQ-015 rsp_rdata  output  DATA_W  read data; meaningful only when rsp_we = 0.
REQ-016 grant  input  1  this client's slot from the round-robin VRAM arbiter.
REQ-017 vram_addr  output  ADDR_W  address presented to the arbiter.
REQ-018 vram_wdata  output  DATA_W  write data presented to the arbiter.
REQ-019 vram_we  output  1  write enable presented to the arbiter.
REQ-020 vram_rdata  input  DATA_W  shared VRAM read bus.

Function
REQ-021 States SHALL be IDLE, ARMED, RDWAIT and RESP, with IDLE as the reset state.
REQ-022 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready on a rising edge.
REQ-023 On handshake, req_we, req_addr and req_wdata SHALL be registered and the state SHALL go to ARMED; a grant in the handshake cycle SHALL be ignored.
REQ-024 In ARMED, vram_addr and vram_wdata SHALL be driven from the registered request and held stable until grant is seen.
REQ-025 vram_we SHALL equal (state == ARMED) & registered_we & grant, and SHALL be 0 at all other times.
REQ-026 In ARMED with grant = 1: a write SHALL go to RESP with rsp_we = 1; a read SHALL go to RDWAIT and load a latency counter with READ_LAT.
REQ-027 In RDWAIT the counter SHALL decrement each cycle; on the edge where it reaches 0, vram_rdata SHALL be captured into rsp_rdata with rsp_we = 0, and the state SHALL go to RESP.
REQ-028 Net read timing: grant cycle N, so vram_rdata is sampled at the end of cycle N + READ_LAT and rsp_valid = 1 from cycle N + READ_LAT + 1.
REQ-029 In RESP, rsp_valid SHALL be 1 and rsp_rdata / rsp_we SHALL be held; on rsp_valid & rsp_ready the state SHALL go to IDLE.
REQ-030 While rsp_ready is low, RESP SHALL hold indefinitely, with no new request accepted and no VRAM activity.
REQ-031 Grant pulses while in IDLE, RDWAIT or RESP SHALL be ignored and SHALL NOT assert vram_we.
REQ-032 In ARMED, vram_addr and vram_wdata SHALL reflect the registered request; outside ARMED they SHALL hold their last value, and vram_we SHALL be 0.
REQ-033 Throughput SHALL be one request outstanding at most; the minimum write turnaround is 3 cycles (accept, grant, response handshake).
REQ-034 A write that completed to VRAM SHALL be acknowledged exactly once, and a read SHALL return data captured exactly once.

Reset
REQ-035 While rst = 0, state SHALL be IDLE; req_ready, rsp_valid, rsp_we and vram_we SHALL be 0; rsp_rdata, vram_addr and vram_wdata SHALL be all-zero, with no dependence on clk.
REQ-036 Reset asserted mid-operation (ARMED, RDWAIT or RESP) SHALL abandon the request: any uncommitted write is never issued and any response is dropped.
REQ-037 After rst rises, req_ready SHALL be 1 from the first rising clk edge.

Verification
REQ-038 Write: handshake with addr = 0x05A and wdata pattern A; grant arrives 4 cycles later -> vram_we = 1 for exactly that cycle with addr 0x05A; rsp_valid = 1 and rsp_we = 1 the next cycle.
REQ-039 Read with READ_LAT = 1: addr = 0x1FF, grant at cycle N, vram_rdata = pattern B during N+1 -> rsp_rdata = B and rsp_valid = 1 at N+2.
REQ-040 Grant in the same cycle as the handshake, and grant in RESP -> no vram_we; the access issues only on the next grant, 8 cycles later.
REQ-041 rsp_ready held low for 20 cycles across 3 grant pulses -> rsp_valid stays 1, rsp_rdata is stable, req_ready = 0, vram_we = 0.
REQ-042 rst pulled low while ARMED with a write, one cycle before grant -> vram_we never asserts, and all outputs are 0 immediately without a clk edge.
REQ-043 Back-to-back read then write to addr 0x000 with rsp_ready = 1 -> two responses in order (rsp_we = 0, then 1), with no lost or duplicate accesses.
